// File: rtl/operand2_decoder_if.sv
// Operand-2 decoder bus: instruction handshake, register-file read port and
// shifter-operand handshake. The master modport is the decoder side.
interface operand2_decoder_if;
   localparam int unsigned DW = 32;

   logic          in_Valid;
   logic          out_Ready;
   logic [DW-1:0] in_Instr;
   logic          in_C_flag;
   logic          out_Rf_re;
   logic [3:0]    out_Rf_addr;
   logic [DW-1:0] in_Rf_data;
   logic          out_Valid;
   logic          in_Ready;
   logic [DW-1:0] out_Reg_val;
   logic [DW-1:0] out_Imm_val;
   logic [4:0]    out_Shift_val;
   logic [3:0]    out_Rotate;
   logic [1:0]    out_Shift_type;
   logic          out_C_flag;
   logic          out_Is_imm;
   logic          out_Shift_big;
   logic          out_Undef;

   modport master (
      input  in_Valid, in_Instr, in_C_flag, in_Rf_data, in_Ready,
      output out_Ready, out_Rf_re, out_Rf_addr, out_Valid, out_Reg_val,
             out_Imm_val, out_Shift_val, out_Rotate, out_Shift_type,
             out_C_flag, out_Is_imm, out_Shift_big, out_Undef
   );

   modport slave (
      output in_Valid, in_Instr, in_C_flag, in_Rf_data, in_Ready,
      input  out_Ready, out_Rf_re, out_Rf_addr, out_Valid, out_Reg_val,
             out_Imm_val, out_Shift_val, out_Rotate, out_Shift_type,
             out_C_flag, out_Is_imm, out_Shift_big, out_Undef
   );
endinterface

// File: rtl/operand2_decoder.sv
// Decodes the shifter operand of an ARM data-processing instruction, fetching
// Rm (and Rs for register-specified shifts) from the register file.
// Optional feature macro: REG_SHIFT_EN builds the register-shift (Rs) path;
// without it such encodings are flagged through out_Undef.
module operand2_decoder (
   input  logic               in_Clk,
   input  logic               in_Rst_n,
   operand2_decoder_if.master bus
);
   localparam int unsigned DW = 32;

   typedef enum logic [2:0] {IDLE, RD_RS, RD_RM, CAP, OUT} state_t;

   state_t        r_state, w_state_nxt;
   logic          r_ready, w_ready;
   logic          r_rf_re, w_rf_re;
   logic [3:0]    r_rf_addr, w_rf_addr;
   logic          r_valid, w_valid;
   logic [DW-1:0] r_reg_val, w_reg_val;
   logic [DW-1:0] r_imm_val, w_imm_val;
   logic [4:0]    r_shift_val, w_shift_val;
   logic [3:0]    r_rotate, w_rotate;
   logic [1:0]    r_shift_type, w_shift_type;
   logic          r_c_flag, w_c_flag;
   logic          r_is_imm, w_is_imm;
   logic          r_shift_big, w_shift_big;
   logic          r_undef, w_undef;
`ifdef REG_SHIFT_EN
   logic [3:0]    r_rm, w_rm;
   logic          r_rs_mode, w_rs_mode;
`endif

   // Condition / opcode / Rn / Rd fields are not part of operand 2.
   logic w_unused;
   assign w_unused = ^{bus.in_Instr[31:26], bus.in_Instr[24:12]};

   // Next state and next registered outputs; data holds unless updated.
   always_comb begin
      w_state_nxt  = r_state;
      w_rf_re      = 1'b0;
      w_rf_addr    = r_rf_addr;
      w_reg_val    = r_reg_val;
      w_imm_val    = r_imm_val;
      w_shift_val  = r_shift_val;
      w_rotate     = r_rotate;
      w_shift_type = r_shift_type;
      w_c_flag     = r_c_flag;
      w_is_imm     = r_is_imm;
      w_shift_big  = r_shift_big;
      w_undef      = r_undef;
`ifdef REG_SHIFT_EN
      w_rm         = r_rm;
      w_rs_mode    = r_rs_mode;
`endif
      case (r_state)
         IDLE: begin
            if (bus.in_Valid) begin
               w_reg_val    = '0;
               w_imm_val    = '0;
               w_shift_val  = '0;
               w_rotate     = '0;
               w_shift_type = '0;
               w_is_imm     = 1'b0;
               w_shift_big  = 1'b0;
               w_undef      = 1'b0;
               w_c_flag     = bus.in_C_flag;
`ifdef REG_SHIFT_EN
               w_rs_mode    = 1'b0;
`endif
               if (bus.in_Instr[25]) begin
                  w_is_imm    = 1'b1;
                  w_imm_val   = DW'(bus.in_Instr[7:0]);
                  w_rotate    = bus.in_Instr[11:8];
                  w_state_nxt = OUT;
               end else if (!bus.in_Instr[4]) begin
                  w_shift_val  = bus.in_Instr[11:7];
                  w_shift_type = bus.in_Instr[6:5];
                  w_rf_re      = 1'b1;
                  w_rf_addr    = bus.in_Instr[3:0];
                  w_state_nxt  = RD_RM;
               end else begin
`ifdef REG_SHIFT_EN
                  w_shift_type = bus.in_Instr[6:5];
                  w_rm         = bus.in_Instr[3:0];
                  w_rs_mode    = 1'b1;
                  w_rf_re      = 1'b1;
                  w_rf_addr    = bus.in_Instr[11:8];
                  w_state_nxt  = RD_RS;
`else
                  w_undef      = 1'b1;
                  w_state_nxt  = OUT;
`endif
               end
            end
         end
`ifdef REG_SHIFT_EN
         RD_RS: begin
            w_rf_re     = 1'b1;
            w_rf_addr   = r_rm;
            w_state_nxt = RD_RM;
         end
`endif
         RD_RM: begin
`ifdef REG_SHIFT_EN
            // Rs arrives while Rm is being read; a zero amount is the identity LSL #0.
            if (r_rs_mode) begin
               if (bus.in_Rf_data[7:0] == 8'd0) begin
                  w_shift_type = 2'b00;
                  w_shift_val  = '0;
                  w_shift_big  = 1'b0;
               end else begin
                  w_shift_val  = bus.in_Rf_data[4:0];
                  w_shift_big  = |bus.in_Rf_data[7:5];
               end
            end
`endif
            w_state_nxt = CAP;
         end
         CAP: begin
            w_reg_val   = bus.in_Rf_data;
            w_state_nxt = OUT;
         end
         OUT: begin
            if (bus.in_Ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      w_ready = (w_state_nxt == IDLE);
      w_valid = (w_state_nxt == OUT);
   end

   // State register and registered outputs with synchronous reset.
   always_ff @(posedge in_Clk) begin
      if (!in_Rst_n) begin
         r_state      <= IDLE;
         r_ready      <= 1'b1;
         r_rf_re      <= 1'b0;
         r_rf_addr    <= '0;
         r_valid      <= 1'b0;
         r_reg_val    <= '0;
         r_imm_val    <= '0;
         r_shift_val  <= '0;
         r_rotate     <= '0;
         r_shift_type <= '0;
         r_c_flag     <= 1'b0;
         r_is_imm     <= 1'b0;
         r_shift_big  <= 1'b0;
         r_undef      <= 1'b0;
`ifdef REG_SHIFT_EN
         r_rm         <= '0;
         r_rs_mode    <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_ready      <= w_ready;
         r_rf_re      <= w_rf_re;
         r_rf_addr    <= w_rf_addr;
         r_valid      <= w_valid;
         r_reg_val    <= w_reg_val;
         r_imm_val    <= w_imm_val;
         r_shift_val  <= w_shift_val;
         r_rotate     <= w_rotate;
         r_shift_type <= w_shift_type;
         r_c_flag     <= w_c_flag;
         r_is_imm     <= w_is_imm;
         r_shift_big  <= w_shift_big;
         r_undef      <= w_undef;
`ifdef REG_SHIFT_EN
         r_rm         <= w_rm;
         r_rs_mode    <= w_rs_mode;
`endif
      end
   end

   assign bus.out_Ready      = r_ready;
   assign bus.out_Rf_re      = r_rf_re;
   assign bus.out_Rf_addr    = r_rf_addr;
   assign bus.out_Valid      = r_valid;
   assign bus.out_Reg_val    = r_reg_val;
   assign bus.out_Imm_val    = r_imm_val;
   assign bus.out_Shift_val  = r_shift_val;
   assign bus.out_Rotate     = r_rotate;
   assign bus.out_Shift_type = r_shift_type;
   assign bus.out_C_flag     = r_c_flag;
   assign bus.out_Is_imm     = r_is_imm;
   assign bus.out_Shift_big  = r_shift_big;
   assign bus.out_Undef      = r_undef;
endmodule

// File: tb/tb_operand2_decoder.sv
// Bench for operand2_decoder: a register-file responder, a transaction-level
// model of the decoded operand and its latency, a per-cycle compare process and
// directed vectors with literal expectations.
module tb_operand2_decoder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic chk_en = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   logic [31:0] regs [16];

   always #5 clk = ~clk;

   operand2_decoder_if bus ();

   operand2_decoder dut (
      .in_Clk   (clk),
      .in_Rst_n (rst_n),
      .bus      (bus)
   );

   typedef struct packed {
      logic [31:0] reg_val;
      logic [31:0] imm_val;
      logic [4:0]  sv;
      logic [3:0]  rot;
      logic [1:0]  st;
      logic        c;
      logic        is_imm;
      logic        big;
      logic        undef;
      logic [2:0]  lat;
      logic [1:0]  nrd;
      logic [3:0]  rd0;
      logic [3:0]  rd1;
   } exp_t;

   // What the shifter must receive for an instruction, given the register file.
   function automatic exp_t model_of(input logic [31:0] ins, input logic c);
      exp_t e;
      e   = '0;
      e.c = c;
      if (ins[25]) begin
         e.is_imm  = 1'b1;
         e.imm_val = {24'd0, ins[7:0]};
         e.rot     = ins[11:8];
         e.lat     = 3'd1;
      end else if (!ins[4]) begin
         e.reg_val = regs[ins[3:0]];
         e.sv      = ins[11:7];
         e.st      = ins[6:5];
         e.lat     = 3'd3;
         e.nrd     = 2'd1;
         e.rd0     = ins[3:0];
      end else begin
`ifdef REG_SHIFT_EN
         int amt;
         amt       = int'(regs[ins[11:8]] & 32'hFF);
         e.reg_val = regs[ins[3:0]];
         e.lat     = 3'd4;
         e.nrd     = 2'd2;
         e.rd0     = ins[11:8];
         e.rd1     = ins[3:0];
         if (amt != 0) begin
            e.st  = ins[6:5];
            e.sv  = 5'(amt % 32);
            e.big = (amt >= 32);
         end
`else
         e.undef = 1'b1;
         e.lat   = 3'd1;
`endif
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Register file: data appears the cycle after a read strobe, junk otherwise.
   logic       pend_re = 1'b0;
   logic [3:0] pend_addr = '0;
   always @(negedge clk) begin
      pend_re   = bus.out_Rf_re;
      pend_addr = bus.out_Rf_addr;
   end
   always @(posedge clk) begin
      #1;
      bus.in_Rf_data = pend_re ? regs[pend_addr] : 32'hA5A5_A5A5;
   end

   // Transaction model: busy from acceptance, output due after lat cycles.
   logic m_busy = 1'b0;
   int   m_cnt = 0;
   exp_t m_exp = '0;
   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_cnt  <= 0;
      end else if (!m_busy) begin
         if (bus.in_Valid) begin
            m_busy <= 1'b1;
            m_cnt  <= 1;
            m_exp  <= model_of(bus.in_Instr, bus.in_C_flag);
         end
      end else if (m_cnt >= int'(m_exp.lat)) begin
         if (bus.in_Ready) m_busy <= 1'b0;
      end else begin
         m_cnt <= m_cnt + 1;
      end
   end

   // Per-cycle comparison of DUT outputs with the model.
   always @(negedge clk) begin
      if (chk_en) begin
         logic ev, er;
         ev = m_busy && (m_cnt >= int'(m_exp.lat));
         er = m_busy && (m_cnt <= int'(m_exp.nrd));
         chk("ready", 32'(bus.out_Ready), 32'(!m_busy));
         chk("valid", 32'(bus.out_Valid), 32'(ev));
         chk("rf_re", 32'(bus.out_Rf_re), 32'(er));
         if (er) chk("rf_addr", 32'(bus.out_Rf_addr), 32'(m_cnt == 1 ? m_exp.rd0 : m_exp.rd1));
         if (ev) begin
            chk("reg_val",    bus.out_Reg_val, m_exp.reg_val);
            chk("imm_val",    bus.out_Imm_val, m_exp.imm_val);
            chk("shift_val",  32'(bus.out_Shift_val), 32'(m_exp.sv));
            chk("rotate",     32'(bus.out_Rotate), 32'(m_exp.rot));
            chk("shift_type", 32'(bus.out_Shift_type), 32'(m_exp.st));
            chk("c_flag",     32'(bus.out_C_flag), 32'(m_exp.c));
            chk("is_imm",     32'(bus.out_Is_imm), 32'(m_exp.is_imm));
            chk("shift_big",  32'(bus.out_Shift_big), 32'(m_exp.big));
            chk("undef",      32'(bus.out_Undef), 32'(m_exp.undef));
         end
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_ready"},  32'(bus.out_Ready), 32'd1);
      chk({tag, "_valid"},  32'(bus.out_Valid), 32'd0);
      chk({tag, "_rf_re"},  32'(bus.out_Rf_re), 32'd0);
      chk({tag, "_rf_addr"}, 32'(bus.out_Rf_addr), 32'd0);
      chk({tag, "_reg"},    bus.out_Reg_val, 32'd0);
      chk({tag, "_imm"},    bus.out_Imm_val, 32'd0);
      chk({tag, "_sv"},     32'(bus.out_Shift_val), 32'd0);
      chk({tag, "_rot"},    32'(bus.out_Rotate), 32'd0);
      chk({tag, "_st"},     32'(bus.out_Shift_type), 32'd0);
      chk({tag, "_c"},      32'(bus.out_C_flag), 32'd0);
      chk({tag, "_isimm"},  32'(bus.out_Is_imm), 32'd0);
      chk({tag, "_big"},    32'(bus.out_Shift_big), 32'd0);
      chk({tag, "_undef"},  32'(bus.out_Undef), 32'd0);
   endtask

   // Present one instruction and wait (bounded) until its operand is valid.
   task automatic start(input logic [31:0] ins, input logic c, output int lat);
      @(negedge clk);
      bus.in_Instr  = ins;
      bus.in_C_flag = c;
      bus.in_Valid  = 1'b1;
      @(negedge clk);
      bus.in_Valid  = 1'b0;
      bus.in_C_flag = ~c;
      lat = 1;
      while (!bus.out_Valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.out_Valid) chk("valid_timeout", 32'(bus.out_Valid), 32'd1);
   endtask

   // Hold off the shifter for some cycles, optionally poking a second instruction.
   task automatic finish(input int hold, input logic poke);
      for (int k = 0; k < hold; k++) begin
         if (poke && k == 1) begin
            bus.in_Instr = 32'hE3A000FF;
            bus.in_Valid = 1'b1;
         end else begin
            bus.in_Valid = 1'b0;
         end
         @(negedge clk);
      end
      bus.in_Valid = 1'b0;
      bus.in_Ready = 1'b1;
      @(negedge clk);
      bus.in_Ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int lat;
      int nv;
      bus.in_Valid   = 1'b0;
      bus.in_Ready   = 1'b0;
      bus.in_Instr   = '0;
      bus.in_C_flag  = 1'b0;
      bus.in_Rf_data = '0;
      for (int i = 0; i < 16; i++) regs[i] = 32'h1000_0000 + 32'(i) * 32'h11;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset("rst0");
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // MOV r0, #200 with C set
      start(32'hE3A000C8, 1'b1, lat);
      chk("i027_lat", 32'(lat), 32'd1);
      chk("i027_imm", bus.out_Imm_val, 32'd200);
      chk("i027_isimm", 32'(bus.out_Is_imm), 32'd1);
      chk("i027_rot", 32'(bus.out_Rotate), 32'd0);
      chk("i027_c", 32'(bus.out_C_flag), 32'd1);
      finish(0, 1'b0);

      // ADD r0, r1, r2, LSL #1 with backpressure and an ignored second request
      regs[2] = 32'd2;
      start(32'hE0810082, 1'b0, lat);
      chk("i028_lat", 32'(lat), 32'd3);
      chk("i028_reg", bus.out_Reg_val, 32'd2);
      chk("i028_sv", 32'(bus.out_Shift_val), 32'd1);
      chk("i028_st", 32'(bus.out_Shift_type), 32'd0);
      finish(3, 1'b1);

      // Immediate with maximum rotate
      start(32'hE3A01FFF, 1'b0, lat);
      chk("imm_ff", bus.out_Imm_val, 32'd255);
      chk("imm_rot", 32'(bus.out_Rotate), 32'd15);
      finish(0, 1'b0);

      // ASR #31 of r5
      regs[5] = 32'h8000_0001;
      start(32'hE1A00FC5, 1'b1, lat);
      chk("asr_sv", 32'(bus.out_Shift_val), 32'd31);
      chk("asr_st", 32'(bus.out_Shift_type), 32'd2);
      chk("asr_reg", bus.out_Reg_val, 32'h8000_0001);
      finish(1, 1'b0);

`ifdef REG_SHIFT_EN
      // LSR r2 by r3 with amounts 4, 0x100 (low byte zero) and 40
      regs[2] = 32'd200;
      regs[3] = 32'd4;
      start(32'hE0810332, 1'b0, lat);
      chk("rs4_lat", 32'(lat), 32'd4);
      chk("rs4_st", 32'(bus.out_Shift_type), 32'd1);
      chk("rs4_sv", 32'(bus.out_Shift_val), 32'd4);
      chk("rs4_big", 32'(bus.out_Shift_big), 32'd0);
      chk("rs4_reg", bus.out_Reg_val, 32'd200);
      finish(0, 1'b0);
      regs[3] = 32'h100;
      start(32'hE0810332, 1'b1, lat);
      chk("rs256_st", 32'(bus.out_Shift_type), 32'd0);
      chk("rs256_sv", 32'(bus.out_Shift_val), 32'd0);
      finish(0, 1'b0);
      regs[3] = 32'd40;
      start(32'hE0810332, 1'b0, lat);
      chk("rs40_big", 32'(bus.out_Shift_big), 32'd1);
      chk("rs40_sv", 32'(bus.out_Shift_val), 32'd8);
      finish(0, 1'b0);
`else
      // Register-specified shift is unsupported in this build
      start(32'hE0810332, 1'b1, lat);
      chk("undef_lat", 32'(lat), 32'd1);
      chk("undef_flag", 32'(bus.out_Undef), 32'd1);
      chk("undef_reg", bus.out_Reg_val, 32'd0);
      chk("undef_sv", 32'(bus.out_Shift_val), 32'd0);
      finish(0, 1'b0);
`endif

      // Reset while Rm is being read discards the instruction
      @(negedge clk);
      bus.in_Instr = 32'hE0810082;
      bus.in_Valid = 1'b1;
      @(negedge clk);
      bus.in_Valid = 1'b0;
      chk("rst_mid_re", 32'(bus.out_Rf_re), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_reset("rst_mid");
      nv = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.out_Valid) nv++;
      end
      chk("rst_mid_novalid", 32'(nv), 32'd0);

      // Recovery after reset
      start(32'hE3A0002A, 1'b0, lat);
      chk("post_rst_imm", bus.out_Imm_val, 32'd42);
      finish(0, 1'b0);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
